// File: rtl/fetch_buffer.sv
// fetch_buffer: decoupling queue between instruction fetch and decode.
// Accepts up to FETCH_WIDTH entries per cycle, presents up to DECODE_WIDTH
// oldest entries in program order, back-pressures fetch one cycle early
// through stall_fetch and is emptied by a backend flush.
// Optional macro FETCH_BUFFER_BYPASS_EN: when the queue is empty and decode is
// ready, incoming entries go straight to insts_out in the same cycle.

package fetch_buffer_pkg;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic            valid;
        logic            pred_taken;
        logic [XLEN-1:0] pred_addr;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fb_entry_t;
endpackage

module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH  = 4,
    parameter int unsigned DECODE_WIDTH = 4,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  fb_entry_t [FETCH_WIDTH-1:0]         insts_in,
    input  logic                                insts_in_valid,
    output logic                                stall_fetch,
    output fb_entry_t [DECODE_WIDTH-1:0]        insts_out,
    output logic                                insts_out_valid,
    input  logic                                decode_ready,
    output logic [$clog2(DEPTH):0]              count
);

    localparam int unsigned PTR_W        = $clog2(DEPTH);
    localparam int unsigned CNT_W        = PTR_W + 1;
    localparam int unsigned ENTRY_W      = $bits(fb_entry_t);
    localparam int unsigned STALL_THRESH = DEPTH - 2 * FETCH_WIDTH;

    fb_entry_t                  mem [DEPTH];
    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;

    logic [CNT_W-1:0]           n_in;
    logic [CNT_W-1:0]           n_avail;
    logic [CNT_W-1:0]           n_pop;
    logic [CNT_W-1:0]           n_byp;
    logic [CNT_W-1:0]           n_rem;
    logic [CNT_W-1:0]           n_acc;
    logic [CNT_W-1:0]           space;
    logic                       present_en;
    logic                       run;
    fb_entry_t [FETCH_WIDTH-1:0] in_rem;
    logic [FETCH_WIDTH-1:0]     wr_en;
    logic [PTR_W-1:0]           wr_idx [FETCH_WIDTH];

    // Incoming group size: leading run of set valid bits only.
    always_comb begin
        n_in = '0;
        run  = insts_in_valid;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            run = run & insts_in[i].valid;
            if (run) begin
                n_in = n_in + CNT_W'(1);
            end
        end
    end

    // Presentation window, bypass size, pop size and accepted write count.
    always_comb begin
        present_en = reset && !flush;
        n_avail    = '0;
        if (present_en) begin
            n_avail = (count > CNT_W'(DECODE_WIDTH)) ? CNT_W'(DECODE_WIDTH) : count;
        end
        n_byp = '0;
`ifdef FETCH_BUFFER_BYPASS_EN
        if (present_en && decode_ready && (count == '0)) begin
            n_byp = (n_in > CNT_W'(DECODE_WIDTH)) ? CNT_W'(DECODE_WIDTH) : n_in;
        end
`endif
        n_pop  = decode_ready ? n_avail : '0;
        n_rem  = n_in - n_byp;
        space  = CNT_W'(DEPTH) - count + n_pop;
        n_acc  = (n_rem > space) ? space : n_rem;
        in_rem = insts_in >> (int'(n_byp) * ENTRY_W);
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            wr_en[j]  = present_en && (CNT_W'(j) < n_acc);
            wr_idx[j] = tail + PTR_W'(j);
        end
    end

    // Output slots: stored entries first, then same-cycle bypass entries.
    always_comb begin
        insts_out = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (CNT_W'(i) < n_avail) begin
                insts_out[i]       = mem[head + PTR_W'(i)];
                insts_out[i].valid = 1'b1;
            end
`ifdef FETCH_BUFFER_BYPASS_EN
            else if ((i < FETCH_WIDTH) && (CNT_W'(i) < n_byp)) begin
                insts_out[i]       = insts_in[i];
                insts_out[i].valid = 1'b1;
            end
`endif
        end
        insts_out_valid = (n_avail != '0) || (n_byp != '0);
    end

    // Stall threshold leaves room for the group already in flight.
    always_comb begin
        stall_fetch = reset && (count > CNT_W'(STALL_THRESH));
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clock) begin
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (wr_en[j]) begin
                mem[wr_idx[j]] <= in_rem[j];
            end
        end
    end

    // Pointers and occupancy with synchronous reset and flush.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_pop);
            tail  <= tail + PTR_W'(n_acc);
            count <= count + n_acc - n_pop;
        end
    end

    // Fetch must never push more than the queue can hold.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
                                    (flush || (n_rem <= space)));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a queue-based reference model.
// Honours FETCH_BUFFER_BYPASS_EN for the same-cycle bypass expectations.
`timescale 1ns/1ps
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int FW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 flush;
    fb_entry_t [FW-1:0]   insts_in;
    logic                 insts_in_valid;
    logic                 stall_fetch;
    fb_entry_t [DW-1:0]   insts_out;
    logic                 insts_out_valid;
    logic                 decode_ready;
    logic [4:0]           count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .insts_in        (insts_in),
        .insts_in_valid  (insts_in_valid),
        .stall_fetch     (stall_fetch),
        .insts_out       (insts_out),
        .insts_out_valid (insts_out_valid),
        .decode_ready    (decode_ready),
        .count           (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Build a fetch group: slot i has pc0+4i, valid from mask bit i.
    task automatic set_in(input logic v, input logic [3:0] mask, input logic [31:0] pc0);
        insts_in_valid = v;
        for (int i = 0; i < FW; i++) begin
            insts_in[i].valid      = mask[i];
            insts_in[i].pc         = pc0 + 32'(4 * i);
            insts_in[i].inst       = ~(pc0 + 32'(4 * i));
            insts_in[i].pred_taken = i[0];
            insts_in[i].pred_addr  = pc0 + 32'h100 + 32'(i);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: program-order queue of accepted entries.
    fb_entry_t mq[$];
    bit        model_ok = 1'b0;

    function automatic int lead();
        int n = 0;
        if (!insts_in_valid) return 0;
        for (int i = 0; i < FW; i++) begin
            if (!insts_in[i].valid) return n;
            n++;
        end
        return n;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Advance the model on every clock edge from the same inputs the DUT sees.
    always @(posedge clock) begin
        int nl, nb;
        if (!reset || flush) begin
            mq.delete();
            if (!reset) model_ok = 1'b1;
        end else begin
            nl = lead();
            nb = 0;
            if (BYP && mq.size() == 0 && decode_ready) nb = imin(nl, DW);
            if (decode_ready) repeat (imin(mq.size(), DW)) void'(mq.pop_front());
            for (int k = nb; k < nl; k++)
                if (mq.size() < DEPTH) mq.push_back(insts_in[k]);
        end
    end

    // Compare all outputs against the model every cycle once reset was seen.
    always @(negedge clock) begin
        fb_entry_t [DW-1:0] e;
        logic ev;
        int   nl;
        if (model_ok) begin
            e = '0;
            if (reset && !flush) begin
                for (int i = 0; i < imin(mq.size(), DW); i++) begin
                    e[i] = mq[i];
                    e[i].valid = 1'b1;
                end
                nl = lead();
                if (BYP && mq.size() == 0 && decode_ready)
                    for (int i = 0; i < imin(nl, DW); i++) begin
                        e[i] = insts_in[i];
                        e[i].valid = 1'b1;
                    end
            end
            ev = 1'b0;
            for (int i = 0; i < DW; i++) ev = ev | e[i].valid;
            chk("model_insts_out", insts_out, e);
            chk("model_out_valid", insts_out_valid, ev);
            chk("model_count", count, mq.size());
            chk("model_stall", stall_fetch, reset && (mq.size() > DEPTH - 2 * FW));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt[4]   = '{4, 8, 12, 16};
        int exp_stall[4] = '{0, 0, 1, 1};

        reset = 1'b0; flush = 1'b0; decode_ready = 1'b0;
        set_in(1'b0, 4'h0, 32'h0);
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_valid", insts_out_valid, 0);
        chk("rst_stall", stall_fetch, 0);
        reset = 1'b1;

        // Fill with four full groups, decode stalled.
        for (int g = 0; g < 4; g++) begin
            set_in(1'b1, 4'hF, 32'h1000 + 32'(16 * g));
            tick();
            chk("fill_count", count, exp_cnt[g]);
            chk("fill_stall", stall_fetch, exp_stall[g]);
        end
        set_in(1'b0, 4'h0, 32'h0);
        #1;
        chk("fill_valid", insts_out_valid, 1);
        for (int i = 0; i < DW; i++) chk("fill_pc", insts_out[i].pc, 32'h1000 + 32'(4 * i));

        // Drain completely.
        decode_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_count", count, 12 - 4 * k);
        end
        #1;
        chk("drain_valid", insts_out_valid, 0);

        // Prefix masks.
        decode_ready = 1'b0;
        set_in(1'b1, 4'b0011, 32'h3000); tick(); chk("prefix_a", count, 2);
        set_in(1'b1, 4'b1111, 32'h3010); tick(); chk("prefix_b", count, 6);
        set_in(1'b1, 4'b0101, 32'h3020); tick(); chk("prefix_c", count, 7);
        set_in(1'b0, 4'h0, 32'h0);
        #1;
        chk("prefix_pc0", insts_out[0].pc, 32'h3000);
        chk("prefix_pc2", insts_out[2].pc, 32'h3010);
        chk("prefix_pc3", insts_out[3].pc, 32'h3014);

        // Simultaneous push and pop at count 5.
        decode_ready = 1'b1; tick(); chk("pp_pre", count, 3);
        decode_ready = 1'b0;
        set_in(1'b1, 4'b0011, 32'h4000); tick(); chk("pp_five", count, 5);
        set_in(1'b1, 4'hF, 32'h4010); decode_ready = 1'b1; tick();
        chk("pp_count", count, 5);
        set_in(1'b0, 4'h0, 32'h0); decode_ready = 1'b0;
        #1;
        chk("pp_pc0", insts_out[0].pc, 32'h4004);
        chk("pp_pc1", insts_out[1].pc, 32'h4010);
        chk("pp_pc3", insts_out[3].pc, 32'h4018);

        // Move pointers to slot 14, then push a group that wraps.
        decode_ready = 1'b1; tick(); tick(); chk("wrap_empty", count, 0);
        decode_ready = 1'b0;
        set_in(1'b1, 4'b0001, 32'h5000); tick(); chk("wrap_one", count, 1);
        set_in(1'b0, 4'h0, 32'h0); decode_ready = 1'b1; tick(); chk("wrap_zero", count, 0);
        set_in(1'b1, 4'hF, 32'h1000);
        #1;
        chk("wrap_same_valid", insts_out_valid, BYP);
        tick();
        chk("wrap_count", count, BYP ? 0 : 4);
        set_in(1'b0, 4'h0, 32'h0);
        #1;
        chk("wrap_next_valid", insts_out_valid, !BYP);
        chk("wrap_pc0", insts_out[0].pc, BYP ? 32'h0 : 32'h1000);
        chk("wrap_pc3", insts_out[3].pc, BYP ? 32'h0 : 32'h100C);
        tick();
        chk("wrap_done", count, 0);
        #1;
        chk("wrap_done_valid", insts_out_valid, 0);

        // Bypass behaviour from an empty buffer.
        set_in(1'b1, 4'hF, 32'h2000);
        #1;
        chk("byp_same_valid", insts_out_valid, BYP);
        chk("byp_same_pc0", insts_out[0].pc, BYP ? 32'h2000 : 32'h0);
        tick();
        chk("byp_count", count, BYP ? 0 : 4);
        set_in(1'b0, 4'h0, 32'h0);
        #1;
        chk("byp_next_pc0", insts_out[0].pc, BYP ? 32'h0 : 32'h2000);
        tick();
        chk("byp_done", count, 0);

        // Flush mid-stream at count 10.
        decode_ready = 1'b0;
        set_in(1'b1, 4'hF, 32'h6100); tick();
        set_in(1'b1, 4'hF, 32'h6110); tick();
        set_in(1'b1, 4'b0011, 32'h6120); tick();
        chk("fl_count", count, 10);
        chk("fl_stall", stall_fetch, 1);
        flush = 1'b1; decode_ready = 1'b1;
        set_in(1'b1, 4'hF, 32'h6000);
        #1;
        chk("fl_out_valid", insts_out_valid, 0);
        tick();
        flush = 1'b0; decode_ready = 1'b0;
        set_in(1'b0, 4'h0, 32'h0);
        chk("fl_after_count", count, 0);
        chk("fl_after_stall", stall_fetch, 0);
        #1;
        chk("fl_after_valid", insts_out_valid, 0);
        set_in(1'b1, 4'hF, 32'h7000); tick();
        set_in(1'b0, 4'h0, 32'h0);
        #1;
        chk("fl_refill_count", count, 4);
        chk("fl_refill_pc0", insts_out[0].pc, 32'h7000);

        // Reset in the middle of operation.
        reset = 1'b0;
        set_in(1'b1, 4'hF, 32'h8000);
        #1;
        chk("mr_valid", insts_out_valid, 0);
        tick();
        chk("mr_count", count, 0);
        chk("mr_stall", stall_fetch, 0);
        reset = 1'b1;
        set_in(1'b0, 4'h0, 32'h0);
        tick();
        chk("mr_after_count", count, 0);
        chk("mr_after_valid", insts_out_valid, 0);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Decoupling queue between instruction fetch and decode. Each cycle it accepts up to FETCH_WIDTH fetch-buffer entries (fb_entry_t) from the fetch stage. It presents up to DECODE_WIDTH oldest entries, in program order, to decode. It back-pressures fetch through a stall output that takes effect one cycle late, and it is cleared by a backend flush on mispredict.

Parameters:
FETCH_WIDTH, 4, entries accepted per cycle (matches `FETCH_WIDTH)
DECODE_WIDTH, 4, max entries presented/popped per cycle
DEPTH, 16, queue capacity in entries; power of two, >= 2*FETCH_WIDTH

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset)
flush  input  1  backend redirect; discard all contents
insts_in  input  fb_entry_t[FETCH_WIDTH]  entries from fetch; per-entry .valid forms a prefix mask
insts_in_valid  input  1  insts_in carries a fetch group this cycle
stall_fetch  output  1  to fetch stall; fetch honours it from the next cycle
insts_out  output  fb_entry_t[DECODE_WIDTH]  oldest entries, program order; .valid per slot
insts_out_valid  output  1  at least one insts_out slot valid
decode_ready  input  1  decode consumes all valid insts_out slots this cycle
count  output  $clog2(DEPTH)+1  current occupancy (debug/perf)

Behaviour:
- Storage: circular array of DEPTH fb_entry_t; head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count register of $clog2(DEPTH)+1 bits.
- Enqueue count n_in = insts_in_valid ? number of leading set .valid bits in insts_in : 0. A set bit after a clear bit is ignored.
- Writes go to tail, tail+1, ... in slot order. tail advances by n_in.
- Presentation: n_avail = min(count, DECODE_WIDTH). insts_out[i] = entry at head+i with .valid=1 for i<n_avail. All other slots are all-zero with .valid=0. insts_out_valid = (n_avail != 0).
- Dequeue: when decode_ready=1, pop n_avail entries and advance head by n_avail. Partial pop is not supported.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + n_in - n_pop. Data written this cycle is visible on insts_out no earlier than the next cycle (latency 1).
- stall_fetch = (count > DEPTH - 2*FETCH_WIDTH), combinational from the registered count. This guarantees the group already in flight after the stall is asserted still fits.
- Overflow (n_in > DEPTH - count + n_pop) is illegal. A simulation assertion fires; excess entries are dropped and the pointers saturate at full.
- Full (count==DEPTH): no writes accepted; stall_fetch=1. Empty: insts_out_valid=0; decode_ready is ignored.
- flush=1 has priority over enqueue and dequeue. Next cycle: head=tail=0, count=0. Same-cycle input is discarded. insts_out_valid is forced to 0 in the flush cycle, so nothing is popped.
- Reset (reset==0 at posedge, including mid-operation): head=0, tail=0, count=0. Outputs: insts_out_valid=0, all insts_out .valid=0, stall_fetch=0. Storage contents are don't-care.
- pred_taken, pred_addr, pc and inst fields pass through unmodified.

Optional Feature:
FETCH_BUFFER_BYPASS_EN
- Defined: when count==0, flush=0 and decode_ready=1, the leading min(n_in, DECODE_WIDTH) incoming entries drive insts_out in the same cycle (insts_out_valid=1) and are not written to storage. Any remainder is enqueued at tail. Minimum latency is 0.
- Undefined: no combinational path from insts_in to insts_out. Minimum latency is 1 cycle.

Test Plan:
- Reset then fill: reset=0 for 2 cycles, then 4 groups of 4 valid entries (pc 0x1000..0x103C) with decode_ready=0 -> count=16. stall_fetch rises when count reaches 12 (count>8), i.e. the cycle after the third group is written. insts_out shows pc 0x1000,0x1004,0x1008,0x100C.
- Prefix mask: group with valid 0b0011, then 0b1111 -> count 2 then 6. A group with valid 0b0101 enqueues 1 entry only.
- Drain with wrap: DEPTH=16, tail at 14, enqueue 4 entries, decode_ready=1 every cycle -> entries in slots 14,15,0,1 come out in order 0x1000..0x100C. count returns to 0 and insts_out_valid drops.
- Simultaneous push/pop: count=5, push 4, pop 4 in the same cycle -> count=5 next cycle; head and tail each advance by 4.
- Flush mid-stream: count=10, flush=1 with a valid input group and decode_ready=1 -> insts_out_valid=0 that cycle. Next cycle count=0, stall_fetch=0, and the input group is absent.
- Bypass: with FETCH_BUFFER_BYPASS_EN, empty buffer, decode_ready=1, push pc 0x2000..0x200C -> insts_out valid in the same cycle and count stays 0. Without the macro, output appears one cycle later and count=4 for one cycle.
